// File: rtl/bus_pattern_checker.sv
// Masked bus pattern detector: flags MATCH_REQ consecutive qualified hits, sticky or pulsed, with a saturating detection count.
// Latency: check/busy registered, visible the cycle after the deciding sample; no backpressure, samples taken only when data_ready=1.
module bus_pattern_checker #(
  parameter int                DATA_W    = 12,
  parameter logic [DATA_W-1:0] PATTERN   = 12'hABC,
  parameter logic [DATA_W-1:0] MASK      = 12'hFFF,
  parameter int                MATCH_REQ = 3,
  parameter bit                STICKY    = 1'b1,
  parameter int                CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_ready,
  input  logic              clr,
  output logic              check,
  output logic              busy,
  output logic [CNT_W-1:0]  det_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DET  = 2'd2
  } state_t;

  localparam logic [3:0] MATCH_REQ_4 = 4'(MATCH_REQ);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] run_cnt;
  logic [3:0] run_nxt;
  logic       det_entry;
  logic       hit;
  logic       idle_like;

  assign hit = ((data_in ^ PATTERN) & MASK) == '0;

  // In pulse mode DET lasts one cycle and its sample is judged as if from IDLE.
  assign idle_like = (state == IDLE) || ((state == DET) && !STICKY);

  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    det_entry = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
      run_nxt   = '0;
    end else if (idle_like) begin
      state_nxt = IDLE;
      run_nxt   = '0;
      if (data_ready && hit) begin
        if (MATCH_REQ_4 == 4'd1) begin
          state_nxt = DET;
          det_entry = 1'b1;
        end else begin
          state_nxt = RUN;
          run_nxt   = 4'd1;
        end
      end
    end else begin
      case (state)
        RUN: begin
          if (data_ready) begin
            if (!hit) begin
              state_nxt = IDLE;
              run_nxt   = '0;
            end else if (run_cnt + 4'd1 == MATCH_REQ_4) begin
              state_nxt = DET;
              run_nxt   = '0;
              det_entry = 1'b1;
            end else begin
              run_nxt = run_cnt + 4'd1;
            end
          end
        end
        DET: begin
          state_nxt = DET;
        end
        default: begin
          state_nxt = IDLE;
          run_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state   <= IDLE;
      run_cnt <= '0;
      check   <= 1'b0;
      busy    <= 1'b0;
      det_cnt <= '0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_nxt;
      check   <= (state_nxt == DET);
      busy    <= (state_nxt == RUN);
      if (clr) begin
        det_cnt <= '0;
      end else if (det_entry && (det_cnt != '1)) begin
        det_cnt <= det_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_pattern_checker.sv
// Three checker configurations driven from one stimulus stream, scored against a count-based reference model.
module tb_bus_pattern_checker;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic [11:0] data_in = 12'h000;
  logic        data_ready = 1'b0;
  logic        clr = 1'b0;

  logic       check_a, busy_a;
  logic [7:0] cnt_a;
  logic       check_b, busy_b;
  logic [7:0] cnt_b;
  logic       check_c, busy_c;
  logic [1:0] cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_pattern_checker #(.DATA_W(12), .PATTERN(12'hABC), .MASK(12'hFFF), .MATCH_REQ(3),
                        .STICKY(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rst_(rst_), .data_in(data_in), .data_ready(data_ready), .clr(clr),
    .check(check_a), .busy(busy_a), .det_cnt(cnt_a));

  bus_pattern_checker #(.DATA_W(12), .PATTERN(12'hABC), .MASK(12'hFF0), .MATCH_REQ(3),
                        .STICKY(1'b1), .CNT_W(8)) u_b (
    .clk(clk), .rst_(rst_), .data_in(data_in), .data_ready(data_ready), .clr(clr),
    .check(check_b), .busy(busy_b), .det_cnt(cnt_b));

  bus_pattern_checker #(.DATA_W(12), .PATTERN(12'hABC), .MASK(12'hFFF), .MATCH_REQ(3),
                        .STICKY(1'b0), .CNT_W(2)) u_c (
    .clk(clk), .rst_(rst_), .data_in(data_in), .data_ready(data_ready), .clr(clr),
    .check(check_c), .busy(busy_c), .det_cnt(cnt_c));

  typedef struct packed {
    logic [2:0] chk;
    logic [2:0] bsy;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: per configuration, a plain count of consecutive hits and a detection flag.
  localparam int          MR = 3;
  localparam logic [11:0] PAT = 12'hABC;
  bit          m_sticky[3] = '{1'b1, 1'b1, 1'b0};
  logic [11:0] m_mask[3]   = '{12'hFFF, 12'hFF0, 12'hFFF};
  int          m_cmax[3]   = '{255, 255, 3};
  int          m_run[3]    = '{0, 0, 0};
  int          m_cnt[3]    = '{0, 0, 0};
  bit          m_det[3]    = '{1'b0, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [11:0] d, input logic r, input logic c, input logic rs);
    exp_t e;
    @(negedge clk);
    data_in    = d;
    data_ready = r;
    clr        = c;
    rst_       = rs;
    for (int i = 0; i < 3; i++) begin
      if (rs || c) begin
        m_run[i] = 0;
        m_cnt[i] = 0;
        m_det[i] = 1'b0;
      end else if (!(m_sticky[i] && m_det[i])) begin
        m_det[i] = 1'b0;
        if (r) begin
          if (((d ^ PAT) & m_mask[i]) == 12'h000) begin
            m_run[i]++;
            if (m_run[i] == MR) begin
              m_run[i] = 0;
              m_det[i] = 1'b1;
              if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      e.chk[i] = m_det[i];
      e.bsy[i] = (m_run[i] > 0);
    end
    e.c0 = 8'(m_cnt[0]);
    e.c1 = 8'(m_cnt[1]);
    e.c2 = 8'(m_cnt[2]);
    exp_q.push_back(e);
  endtask

  // Monitor: compares every registered output just after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_check", {7'd0, check_a}, {7'd0, e.chk[0]});
        chk("a_busy",  {7'd0, busy_a},  {7'd0, e.bsy[0]});
        chk("a_cnt",   cnt_a,           e.c0);
        chk("b_check", {7'd0, check_b}, {7'd0, e.chk[1]});
        chk("b_busy",  {7'd0, busy_b},  {7'd0, e.bsy[1]});
        chk("b_cnt",   cnt_b,           e.c1);
        chk("c_check", {7'd0, check_c}, {7'd0, e.chk[2]});
        chk("c_busy",  {7'd0, busy_c},  {7'd0, e.bsy[2]});
        chk("c_cnt",   {6'd0, cnt_c},   e.c2);
      end
    end
  end

  initial begin
    logic [11:0] d;
    // reset, then pattern present but never qualified
    repeat (3) step(12'hABC, 1'b0, 1'b0, 1'b1);
    repeat (10) step(12'hABC, 1'b0, 1'b0, 1'b0);
    // basic sticky detect, then clear
    repeat (3) step(12'hABC, 1'b1, 1'b0, 1'b0);
    repeat (3) step(12'h000, 1'b1, 1'b0, 1'b0);
    step(12'h000, 1'b0, 1'b1, 1'b0);
    // broken run, then gaps that do not break a run
    step(12'hABC, 1'b1, 1'b0, 1'b0);
    step(12'hABC, 1'b1, 1'b0, 1'b0);
    step(12'h123, 1'b1, 1'b0, 1'b0);
    step(12'hABC, 1'b1, 1'b0, 1'b0);
    repeat (4) step(12'h000, 1'b0, 1'b0, 1'b0);
    step(12'hABC, 1'b1, 1'b0, 1'b0);
    step(12'hABC, 1'b1, 1'b0, 1'b0);
    step(12'h000, 1'b0, 1'b0, 1'b0);
    step(12'h000, 1'b0, 1'b1, 1'b0);
    // masked compare
    step(12'hAB5, 1'b1, 1'b0, 1'b0);
    step(12'hABF, 1'b1, 1'b0, 1'b0);
    step(12'hAB0, 1'b1, 1'b0, 1'b0);
    step(12'h000, 1'b0, 1'b1, 1'b0);
    step(12'hAB5, 1'b1, 1'b0, 1'b0);
    step(12'hAC0, 1'b1, 1'b0, 1'b0);
    step(12'h000, 1'b0, 1'b1, 1'b0);
    // pulse mode with saturating 2-bit count
    repeat (15) step(12'hABC, 1'b1, 1'b0, 1'b0);
    step(12'h000, 1'b0, 1'b0, 1'b0);
    step(12'h000, 1'b0, 1'b1, 1'b0);
    // clr wins over the third hit sample
    step(12'hABC, 1'b1, 1'b0, 1'b0);
    step(12'hABC, 1'b1, 1'b0, 1'b0);
    step(12'hABC, 1'b1, 1'b1, 1'b0);
    step(12'h000, 1'b0, 1'b0, 1'b0);
    // async reset mid-cycle during a run
    step(12'hABC, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_ = 1'b1;
    #1;
    chk("async_busy",  {7'd0, busy_a},  8'd0);
    chk("async_check", {7'd0, check_a}, 8'd0);
    chk("async_cnt_c", {6'd0, cnt_c},   8'd0);
    step(12'hABC, 1'b1, 1'b0, 1'b1);
    step(12'hABC, 1'b1, 1'b0, 1'b0);
    // randomized traffic biased toward near-matches
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    d = 12'hABC;
        2:       d = {8'hAB, 4'($urandom_range(0, 15))};
        default: d = 12'($urandom);
      endcase
      step(d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0), ($urandom_range(0, 200) == 0));
    end
    step(12'h000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_pattern_checker.md
Name: bus_pattern_checker

Overview:
- Parametrised successor to the single-nibble pattern checker. Compares a qualified DATA_W-bit bus against a masked pattern.
- Asserts `check` only after MATCH_REQ consecutive qualified matches.
- Check is sticky until cleared, or a one-cycle pulse, selected by parameter.
- Keeps a saturating count of detection events.
- Sits on the capture side of the data bus, beside the bus-check logic, and feeds status and interrupt logic.

Parameters:
- DATA_W, 12, width of data_in, PATTERN and MASK (legal 1..32).
- PATTERN, 12'hABC, value to detect.
- MASK, 12'hFFF, per-bit compare enable; 1 = bit compared, 0 = don't care.
- MATCH_REQ, 3, consecutive qualified matches required for detection (legal 1..15).
- STICKY, 1, 1 = check holds until clr; 0 = check pulses one cycle per detection.
- CNT_W, 8, width of det_cnt.

Ports:
- clk, input, 1, rising-edge clock.
- rst_, input, 1, reset; asynchronous, active-high.
- data_in, input, DATA_W, bus value under test.
- data_ready, input, 1, qualifies data_in; a sample is taken only on cycles where data_ready=1.
- clr, input, 1, synchronous clear of detection state, run count and det_cnt.
- check, output, 1, detection flag; registered.
- busy, output, 1, 1 while a partial run is in progress (state RUN).
- det_cnt, output, CNT_W, number of detection events since reset/clr; saturating.

Behaviour:
- Reset (rst_=1, async): state=IDLE, run_cnt=0, check=0, busy=0, det_cnt=0. All outputs are held at these values while rst_ is high.
- hit = (((data_in ^ PATTERN) & MASK) == 0). A sample = a rising clk edge with data_ready=1.
- run_cnt width = 4 bits. It counts consecutive hit samples.
  - Cycles with data_ready=0 hold run_cnt and state; they do not break a run.
  - A non-hit sample resets run_cnt to 0 and moves state to IDLE.
- States:
  - IDLE (run_cnt=0):
    - hit sample with MATCH_REQ=1 -> DET.
    - hit sample with MATCH_REQ>1 -> RUN, run_cnt=1.
  - RUN:
    - hit sample -> run_cnt+1. Go to DET when run_cnt+1 == MATCH_REQ; otherwise stay in RUN.
    - non-hit sample -> IDLE.
  - DET, STICKY=1:
    - check=1; all samples are ignored.
    - Remains in DET until clr.
  - DET, STICKY=0:
    - DET is transient: check=1 for exactly one cycle.
    - Next state is computed as from IDLE, with run_cnt=0. Detection is non-overlapping: a new detection needs MATCH_REQ fresh hit samples after the detecting one.
    - A sample arriving on the DET cycle is evaluated as an IDLE sample.
- Latency: check rises on the clk edge that registers the MATCH_REQ-th hit sample. It is visible the cycle after that sample is presented.
- busy = (state == RUN); registered.
- det_cnt:
  - Increments by 1 on each entry to DET.
  - Saturates at 2^CNT_W-1; no wrap.
- clr:
  - Next edge: state=IDLE, run_cnt=0, check=0, det_cnt=0.
  - clr has priority over a simultaneous sample; that sample is discarded, and does not count toward a run.
- Reset mid-run: run progress is lost. The run restarts from IDLE after rst_ deasserts.
- MATCH_REQ=1, MASK=all ones, STICKY=0 reproduces the legacy single-compare checker, with one cycle of registered latency.

Test Plan:
- Reset/idle: rst_=1 for 3 cycles, then drive data_in=12'hABC with data_ready=0 for 10 cycles -> check=0, busy=0, det_cnt=0 throughout.
- Basic detect (STICKY=1): 3 consecutive ready samples of 12'hABC -> busy=1 after sample 1 and sample 2. check=1 the cycle after sample 3; det_cnt=1. Further 12'h000 samples leave check=1. clr -> check=0, det_cnt=0.
- Broken run and gaps: samples ABC, ABC, 123, ABC, then data_ready=0 for 4 cycles, then ABC, ABC -> no detection until the final ABC. check rises the following cycle; det_cnt=1.
- Mask: MASK=12'hFF0, samples 12'hAB5, 12'hABF, 12'hAB0 -> detection. A sample of 12'hAC0 mid-run -> run resets, busy=0.
- Pulse mode (STICKY=0, CNT_W=2): 15 consecutive ABC samples -> 5 one-cycle check pulses, one after every 3rd sample. det_cnt goes 1, 2, 3, 3, 3 (saturated).
- Priority/async: clr asserted on the same cycle as the 3rd hit sample -> no detection, det_cnt=0. rst_ pulsed mid-clock during RUN -> busy=0 immediately, without waiting for a clock edge.
